// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU
// and command codes, condition codes, and the per-state Moore control word.
// Latency: n/a (types/constants only). Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  // Ungated Moore control word; write enables are qualified by CondEx later.
  typedef struct packed {
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       aluop;
    logic       branch;
  } ctl_t;

  function automatic ctl_t moore(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
                    c.irwrite = 1'b1; c.nextpc = 1'b1; end
      DECODE: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
      MEMADR: c.alusrcb = 2'b01;
      MEMRD:  c.adrsrc = 1'b1;
      MEMWB:  begin c.resultsrc = 2'b01; c.regw = 1'b1; end
      MEMWR:  begin c.adrsrc = 1'b1; c.memw = 1'b1; end
      EXECR:  c.aluop = 1'b1;
      EXECI:  begin c.alusrcb = 2'b01; c.aluop = 1'b1; end
      ALUWB:  c.regw = 1'b1;
      BRANCH: begin c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.branch = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// enables/selects and debug state out.
// Latency: n/a (wiring only). Backpressure: none, controller is never stalled.
// Ports: master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [3:0] State;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
  );
endinterface

// File: rtl/condlogic.sv
// Flags register {N,Z,C,V}, condition evaluation and the CondEx latch for ALUWB.
// Latency: CondEx combinational from registered Flags; Flags update at EXEC cycle end.
// Backpressure: none.
// Ports: clk/reset, Cond, ALUFlags, FlagW, exec (EXECR/EXECI), wb (ALUWB) -> CondEx.
module condlogic
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       exec,
  input  logic       wb,
  output logic       CondEx
);

  logic [3:0] flags;
  logic       condex_now;
  logic       condex_q;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    condex_now = 1'b0;
    case (Cond)
      CC_EQ: condex_now = z;
      CC_NE: condex_now = ~z;
      CC_CS: condex_now = c;
      CC_CC: condex_now = ~c;
      CC_MI: condex_now = n;
      CC_PL: condex_now = ~n;
      CC_VS: condex_now = v;
      CC_VC: condex_now = ~v;
      CC_HI: condex_now = c & ~z;
      CC_LS: condex_now = ~c | z;
      CC_GE: condex_now = (n == v);
      CC_LT: condex_now = (n != v);
      CC_GT: condex_now = ~z & (n == v);
      CC_LE: condex_now = z | (n != v);
      CC_AL: condex_now = 1'b1;
      default: condex_now = 1'b0;
    endcase
  end

  // The EXEC-cycle decision is frozen so a flag-setting instruction's own
  // writeback is not re-judged against the flags it just produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags    <= 4'b0000;
      condex_q <= 1'b0;
    end else if (exec) begin
      condex_q <= condex_now;
      if (FlagW[1] & condex_now) flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] & condex_now) flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign CondEx = wb ? condex_q : condex_now;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: main FSM, ALU/flag decode, gated write enables.
// Latency: LDR 5, STR 4, data-processing 4, branch 3, undefined 2 cycles.
// Backpressure: none; one state per clock. Ports: clk, reset, bus (master modport).
module multicycle_controller
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  state_t     state;
  ctl_t       ctl;
  logic [3:0] cmd;
  logic       legal;
  logic [1:0] aluctl;
  logic [1:0] flagw;
  logic       condex;
  logic       rd15;
  logic       pcs;

  function automatic state_t next_state(state_t s, logic [1:0] op, logic [5:0] funct);
    case (s)
      FETCH:  return DECODE;
      DECODE: case (op)
                OP_DP:   return funct[5] ? EXECI : EXECR;
                OP_MEM:  return MEMADR;
                OP_BR:   return BRANCH;
                default: return FETCH;
              endcase
      MEMADR: return funct[0] ? MEMRD : MEMWR;
      MEMRD:  return MEMWB;
      EXECR:  return ALUWB;
      EXECI:  return ALUWB;
      default: return FETCH;
    endcase
  endfunction

  // Control word is registered from the next state so it lines up with State.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= moore(FETCH);
    end else begin
      state <= next_state(state, bus.Op, bus.Funct);
      ctl   <= moore(next_state(state, bus.Op, bus.Funct));
    end
  end

  assign cmd = bus.Funct[4:1];

  always_comb begin
    legal  = 1'b1;
    aluctl = ALU_ADD;
    flagw  = 2'b00;
    case (cmd)
      CMD_ADD: aluctl = ALU_ADD;
      CMD_SUB: aluctl = ALU_SUB;
      CMD_AND: aluctl = ALU_AND;
      CMD_ORR: aluctl = ALU_ORR;
      default: legal = 1'b0;
    endcase
    if (!ctl.aluop) aluctl = ALU_ADD;
    if (ctl.aluop && bus.Funct[0] && legal)
      flagw = {1'b1, (cmd == CMD_ADD) || (cmd == CMD_SUB)};
  end

  condlogic u_condlogic (
    .clk      (clk),
    .reset    (reset),
    .Cond     (bus.Cond),
    .ALUFlags (bus.ALUFlags),
    .FlagW    (flagw),
    .exec     (ctl.aluop),
    .wb       (state == ALUWB),
    .CondEx   (condex)
  );

  // Writing R15 is a jump: it goes to the PC instead of the register file.
  assign rd15 = (bus.Rd == 4'd15);
  assign pcs  = ctl.branch | (ctl.regw & rd15);

  assign bus.PCWrite    = ~reset & (ctl.nextpc | (pcs & condex));
  assign bus.RegWrite   = ~reset & ctl.regw & condex & ~rd15;
  assign bus.MemWrite   = ~reset & ctl.memw & condex;
  assign bus.IRWrite    = ~reset & ctl.irwrite;
  assign bus.AdrSrc     = ctl.adrsrc;
  assign bus.ALUSrcA    = ctl.alusrca;
  assign bus.ALUSrcB    = ctl.alusrcb;
  assign bus.ResultSrc  = ctl.resultsrc;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
  assign bus.ALUControl = aluctl;
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed instructions then random ones, with occasional
// mid-instruction resets, compared against an instruction-level model.
// Latency: n/a. Backpressure: n/a.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int errors  = 0;

  // Per-state row: {AdrSrc,ALUSrcA,ALUSrcB[1:0],ResultSrc[1:0],IRW,NextPC,RegW,MemW,ALUOp,Branch}
  logic [11:0] tbl [0:9];
  logic [3:0]  m_flags;
  logic        m_cx_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: apply reset/ALUFlags, check at negedge, advance the model.
  task automatic do_cycle(input int st, input logic rst_now, input logic [3:0] af);
    logic [11:0] row;
    logic        cx, rd15, pcs;
    logic [3:0]  cmd;
    logic [1:0]  ac;
    reset = rst_now;
    bus.ALUFlags = af;
    @(negedge clk);
    row  = tbl[st];
    cmd  = bus.Funct[4:1];
    rd15 = (bus.Rd == 4'd15);
    cx   = (st == 8) ? m_cx_lat : cond_true(bus.Cond, m_flags);
    pcs  = row[0] | (row[3] & rd15);
    check("State", 32'(bus.State), 32'(st));
    if (rst_now) begin
      check("PCWrite_rst",  32'(bus.PCWrite),  32'd0);
      check("RegWrite_rst", 32'(bus.RegWrite), 32'd0);
      check("MemWrite_rst", 32'(bus.MemWrite), 32'd0);
      check("IRWrite_rst",  32'(bus.IRWrite),  32'd0);
      m_flags  = 4'b0000;
      m_cx_lat = 1'b0;
    end else begin
      ac = !row[1] ? 2'd0 : (cmd == 4'd4) ? 2'd0 : (cmd == 4'd2) ? 2'd1 :
           (cmd == 4'd0) ? 2'd2 : (cmd == 4'd12) ? 2'd3 : 2'd0;
      check("PCWrite",    32'(bus.PCWrite),    32'(row[4] | (pcs & cx)));
      check("RegWrite",   32'(bus.RegWrite),   32'(row[3] & cx & !rd15));
      check("MemWrite",   32'(bus.MemWrite),   32'(row[2] & cx));
      check("IRWrite",    32'(bus.IRWrite),    32'(row[5]));
      check("AdrSrc",     32'(bus.AdrSrc),     32'(row[11]));
      check("ALUSrcA",    32'(bus.ALUSrcA),    32'(row[10]));
      check("ALUSrcB",    32'(bus.ALUSrcB),    32'(row[9:8]));
      check("ResultSrc",  32'(bus.ResultSrc),  32'(row[7:6]));
      check("ImmSrc",     32'(bus.ImmSrc),     32'(bus.Op));
      check("RegSrc",     32'(bus.RegSrc),     32'({bus.Op == 2'b01, bus.Op == 2'b10}));
      check("ALUControl", 32'(bus.ALUControl), 32'(ac));
      if (st == 6 || st == 7) begin
        m_cx_lat = cx;
        if (bus.Funct[0] && cx && (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd0 || cmd == 4'd12)) begin
          m_flags[3:2] = af[3:2];
          if (cmd == 4'd4 || cmd == 4'd2) m_flags[1:0] = af[1:0];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; abort >= 0 asserts reset during that cycle index.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic fix, input logic [3:0] afv,
                           input int abort);
    int q[$];
    logic [3:0] af;
    case (op)
      2'b00:   q = funct[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b01:   q = funct[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b10:   q = '{0, 1, 9};
      default: q = '{0, 1};
    endcase
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd;
    foreach (q[i]) begin
      af = fix ? afv : 4'($urandom);
      if (i == abort) begin
        do_cycle(q[i], 1'b1, af);
        do_cycle(0, 1'b1, af);
        return;
      end
      do_cycle(q[i], 1'b0, af);
    end
  endtask

  initial begin
    logic [3:0] cmds [0:3];
    logic [3:0] rcond, rrd, rcmd;
    logic [1:0] rop;
    logic [5:0] rfn;
    int         ab;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;
    tbl[0] = 12'b0_1_10_10_1_1_0_0_0_0;
    tbl[1] = 12'b0_1_10_10_0_0_0_0_0_0;
    tbl[2] = 12'b0_0_01_00_0_0_0_0_0_0;
    tbl[3] = 12'b1_0_00_00_0_0_0_0_0_0;
    tbl[4] = 12'b0_0_00_01_0_0_1_0_0_0;
    tbl[5] = 12'b1_0_00_00_0_0_0_1_0_0;
    tbl[6] = 12'b0_0_00_00_0_0_0_0_1_0;
    tbl[7] = 12'b0_0_01_00_0_0_0_0_1_0;
    tbl[8] = 12'b0_0_00_00_0_0_1_0_0_0;
    tbl[9] = 12'b0_0_01_10_0_0_0_0_0_1;
    m_flags = 4'b0000; m_cx_lat = 1'b0;
    reset = 1'b1;
    bus.Cond = 4'd0; bus.Op = 2'd0; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
    @(posedge clk); #1;
    do_cycle(0, 1'b1, 4'd0);

    // Directed: BEQ right after reset (flags clear -> not taken), LDR, STR.
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 1'b1, 4'd0, -1);
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd3, 1'b1, 4'd0, -1);
    run_instr(4'b1110, 2'b01, 6'b011000, 4'd3, 1'b1, 4'd0, -1);
    // ADDS with Z from the ALU, then BNE not taken; clear Z, BNE taken.
    run_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 1'b1, 4'b0100, -1);
    run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 1'b1, 4'd0, -1);
    run_instr(4'b1110, 2'b00, 6'b101001, 4'd2, 1'b1, 4'b0000, -1);
    run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 1'b1, 4'd0, -1);
    // SUB to R15 and ORRS to R15: PC written, register file not.
    run_instr(4'b1110, 2'b00, 6'b000100, 4'd15, 1'b1, 4'd0, -1);
    run_instr(4'b1110, 2'b00, 6'b111001, 4'd15, 1'b1, 4'b1011, -1);
    // Flag-setting instruction whose own condition fails: flags must hold.
    run_instr(4'b0000, 2'b00, 6'b001001, 4'd4, 1'b1, 4'b0100, -1);
    run_instr(4'b1101, 2'b10, 6'b000000, 4'd0, 1'b1, 4'd0, -1);
    // Reset while in MEMRD, then undefined op and an illegal cmd with S set.
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd5, 1'b1, 4'd0, 3);
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 1'b1, 4'd0, -1);
    run_instr(4'b1110, 2'b11, 6'b111111, 4'd15, 1'b1, 4'd0, -1);
    run_instr(4'b1110, 2'b00, 6'b011111, 4'd6, 1'b1, 4'b1111, -1);
    run_instr(4'b1111, 2'b00, 6'b001000, 4'd6, 1'b1, 4'd0, -1);

    for (int k = 0; k < 400; k++) begin
      rcond = 4'($urandom);
      rop   = 2'($urandom);
      rcmd  = ($urandom_range(0, 3) != 0) ? cmds[$urandom_range(0, 3)] : 4'($urandom);
      rfn   = {1'($urandom), rcmd, 1'($urandom)};
      rrd   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      ab    = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(rcond, rop, rfn, rrd, 1'b0, 4'd0, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
